// File: rtl/cmd_dec.sv
// cmd_dec: command-frame decoder that loads per-channel PWM targets and pending-update flags.
// Define CMD_DEC_CRC_EN to include the serial CRC-4 check; otherwise frames go straight to CHECK.
module cmd_dec #(
  parameter int NUM_CH = 12,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                       fpga_clock,
  input  logic                       reset,
  input  logic                       frame_valid,
  input  logic [4+ADDR_W+DATA_W-1:0] frame_data,
  input  logic [NUM_CH-1:0]          pwm_done,
  output logic [NUM_CH*DATA_W-1:0]   pwm_target,
  output logic [NUM_CH-1:0]          pwm_update,
  output logic                       busy,
  output logic                       crc_error,
  output logic [7:0]                 crc_err_cnt,
  output logic [7:0]                 drop_cnt
);

  localparam int FRAME_W = 4 + ADDR_W + DATA_W;
  localparam int MSG_W   = ADDR_W + DATA_W;

  if ((2 ** ADDR_W) <= NUM_CH) begin : g_addr_chk
    $error("cmd_dec: 2**ADDR_W must exceed NUM_CH");
  end
  if ((NUM_CH < 1) || (NUM_CH > 15)) begin : g_ch_chk
    $error("cmd_dec: NUM_CH must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CRC   = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [MSG_W-1:0]           msg_q, msg_d;
  logic [NUM_CH*DATA_W-1:0]   target_q, target_d;
  logic [NUM_CH-1:0]          update_q, update_d;
  logic [NUM_CH-1:0]          wr_s;
  logic [7:0]                 drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0]          addr_s;
  logic [DATA_W-1:0]          data_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Address 0 broadcasts; 1..NUM_CH select one channel; anything above selects none.
  function automatic logic [NUM_CH-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NUM_CH-1:0] sel;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i] = (a == {ADDR_W{1'b0}}) || (a == ADDR_W'(i + 1));
    end
    return sel;
  endfunction

  assign addr_s = msg_q[MSG_W-1 -: ADDR_W];
  assign data_s = msg_q[DATA_W-1:0];

`ifdef CMD_DEC_CRC_EN
  localparam int CNT_W = $clog2(MSG_W);

  logic [3:0]       crc_q, crc_d;
  logic [3:0]       rx_crc_q, rx_crc_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] bit_sel_s;
  logic             crc_error_q, crc_error_d;
  logic [7:0]       crc_cnt_q, crc_cnt_d;

  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic b);
    logic fb;
    fb = crc[3] ^ b;
    return {crc[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
  endfunction

  assign bit_sel_s   = CNT_W'(MSG_W - 1) - bit_q;
  assign crc_error   = crc_error_q;
  assign crc_err_cnt = crc_cnt_q;
`else
  logic unused_crc_field;
  assign unused_crc_field = ^frame_data[FRAME_W-1:MSG_W];
  assign crc_error        = 1'b0;
  assign crc_err_cnt      = 8'h00;
`endif

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    target_d = target_q;
    update_d = update_q & ~pwm_done;
    wr_s     = {NUM_CH{1'b0}};
`ifdef CMD_DEC_CRC_EN
    crc_d       = crc_q;
    rx_crc_d    = rx_crc_q;
    bit_d       = bit_q;
    crc_error_d = 1'b0;
    crc_cnt_d   = crc_cnt_q;
`endif

    if (frame_valid && (state_q != ST_IDLE)) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_valid) begin
          msg_d = frame_data[MSG_W-1:0];
`ifdef CMD_DEC_CRC_EN
          crc_d    = 4'h0;
          rx_crc_d = frame_data[FRAME_W-1 -: 4];
          bit_d    = {CNT_W{1'b0}};
          state_d  = ST_CRC;
`else
          state_d  = ST_CHECK;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef CMD_DEC_CRC_EN
      ST_CRC: begin
        crc_d = crc4_step(crc_q, msg_q[bit_sel_s]);
        bit_d = bit_q + CNT_W'(1);
        if (bit_q == CNT_W'(MSG_W - 1)) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_CRC;
        end
      end
`endif
      ST_CHECK: begin
        state_d = ST_IDLE;
`ifdef CMD_DEC_CRC_EN
        if (crc_q != rx_crc_q) begin
          crc_error_d = 1'b1;
          crc_cnt_d   = sat_inc(crc_cnt_q);
        end else begin
          wr_s = decode(addr_s);
        end
`else
        wr_s = decode(addr_s);
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A write wins over a coincident pwm_done so the new target is never lost.
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_s[i]) begin
        target_d[i*DATA_W +: DATA_W] = data_s;
        update_d[i]                  = 1'b1;
      end else begin
        target_d[i*DATA_W +: DATA_W] = target_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      msg_q      <= {MSG_W{1'b0}};
      target_q   <= {(NUM_CH*DATA_W){1'b0}};
      update_q   <= {NUM_CH{1'b0}};
      drop_cnt_q <= 8'h00;
`ifdef CMD_DEC_CRC_EN
      crc_q       <= 4'h0;
      rx_crc_q    <= 4'h0;
      bit_q       <= {CNT_W{1'b0}};
      crc_error_q <= 1'b0;
      crc_cnt_q   <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      target_q   <= target_d;
      update_q   <= update_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef CMD_DEC_CRC_EN
      crc_q       <= crc_d;
      rx_crc_q    <= rx_crc_d;
      bit_q       <= bit_d;
      crc_error_q <= crc_error_d;
      crc_cnt_q   <= crc_cnt_d;
`endif
    end
  end

  assign pwm_target = target_q;
  assign pwm_update = update_q;
  assign busy       = (state_q != ST_IDLE);
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_cmd_dec.sv
// tb_cmd_dec: table-driven check of cmd_dec at default parameters, plus directed
// sequences for drops, coincident pwm_done, counter saturation and reset mid-frame.
module tb_cmd_dec;

`ifdef CMD_DEC_CRC_EN
  localparam int         LAT  = 13;
  localparam int         GAP  = 3;
  localparam logic [7:0] ERR1 = 8'd1;
`else
  localparam int         LAT  = 1;
  localparam int         GAP  = 1;
  localparam logic [7:0] ERR1 = 8'd0;
`endif

  logic        fpga_clock;
  logic        reset;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic [11:0] pwm_done;
  logic [95:0] pwm_target;
  logic [11:0] pwm_update;
  logic        busy;
  logic        crc_error;
  logic [7:0]  crc_err_cnt;
  logic [7:0]  drop_cnt;

  int n_checks;
  int n_fail;

  cmd_dec dut (
    .fpga_clock (fpga_clock),
    .reset      (reset),
    .frame_valid(frame_valid),
    .frame_data (frame_data),
    .pwm_done   (pwm_done),
    .pwm_target (pwm_target),
    .pwm_update (pwm_update),
    .busy       (busy),
    .crc_error  (crc_error),
    .crc_err_cnt(crc_err_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial fpga_clock = 1'b0;
  always #5 fpga_clock = ~fpga_clock;

  typedef struct {
    logic [15:0] frame;
    logic [95:0] exp_tgt;
    logic [11:0] exp_upd;
    logic        exp_err;
    logic [7:0]  exp_cnt;
    logic [11:0] done;
    logic [11:0] exp_upd_after;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  function automatic logic [3:0] crc4(input logic [11:0] m);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 11; i >= 0; i--) begin
      fb = c[3] ^ m[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return c;
  endfunction

  function automatic logic [15:0] mk(input logic [3:0] a, input logic [7:0] d);
    return {crc4({a, d}), a, d};
  endfunction

  task automatic tick();
    @(posedge fpga_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] f);
    frame_data  = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic set_vec(input int k, input logic [15:0] f, input logic [95:0] t,
                         input logic [11:0] u, input logic e, input logic [7:0] c,
                         input logic [11:0] d, input logic [11:0] ua);
    vecs[k].frame         = f;
    vecs[k].exp_tgt       = t;
    vecs[k].exp_upd       = u;
    vecs[k].exp_err       = e;
    vecs[k].exp_cnt       = c;
    vecs[k].done          = d;
    vecs[k].exp_upd_after = ua;
  endtask

  logic [95:0] prev_tgt;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_data  = 16'h0000;
    pwm_done    = 12'h000;

    set_vec(0, 16'hD35A, 96'h00000000_00000000_005A0000, 12'h004, 1'b0, 8'd0, 12'h004, 12'h000);
`ifdef CMD_DEC_CRC_EN
    set_vec(1, 16'h035A, 96'h00000000_00000000_005A0000, 12'h000, 1'b1, 8'd1, 12'h000, 12'h000);
`else
    set_vec(1, 16'h035A, 96'h00000000_00000000_005A0000, 12'h004, 1'b0, 8'd0, 12'h004, 12'h000);
`endif
    set_vec(2, 16'hE080, {12{8'h80}}, 12'hFFF, 1'b0, ERR1, 12'h001, 12'hFFE);
    set_vec(3, mk(4'hC, 8'h3C), 96'h3C808080_80808080_80808080, 12'hFFE, 1'b0, ERR1, 12'hFFF, 12'h000);
    set_vec(4, mk(4'h1, 8'h11), 96'h3C808080_80808080_80808011, 12'h001, 1'b0, ERR1, 12'h000, 12'h001);
    set_vec(5, mk(4'hD, 8'h77), 96'h3C808080_80808080_80808011, 12'h001, 1'b0, ERR1, 12'h001, 12'h000);
    set_vec(6, mk(4'hF, 8'hFF), 96'h3C808080_80808080_80808011, 12'h000, 1'b0, ERR1, 12'h000, 12'h000);

    // Reset values
    tick();
    tick();
    check("rst_target", 128'(pwm_target), 128'(96'h0));
    check("rst_update", 128'(pwm_update), 128'(12'h000));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_crc_error", 128'(crc_error), 128'(1'b0));
    check("rst_crc_cnt", 128'(crc_err_cnt), 128'(8'h00));
    check("rst_drop_cnt", 128'(drop_cnt), 128'(8'h00));

    // frame_valid coincident with reset is ignored
    frame_data  = 16'hD35A;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    reset       = 1'b0;
    check("rstvalid_busy", 128'(busy), 128'(1'b0));
    check("rstvalid_drop", 128'(drop_cnt), 128'(8'h00));
    repeat (LAT + 2) tick();
    check("rstvalid_target", 128'(pwm_target), 128'(96'h0));

    // Table-driven frames
    prev_tgt = 96'h0;
    for (int k = 0; k < NV; k++) begin
      send(vecs[k].frame);
      repeat (LAT - 1) tick();
      check($sformatf("v%0d_early_target", k), 128'(pwm_target), 128'(prev_tgt));
      check($sformatf("v%0d_early_busy", k), 128'(busy), 128'(1'b1));
      tick();
      check($sformatf("v%0d_target", k), 128'(pwm_target), 128'(vecs[k].exp_tgt));
      check($sformatf("v%0d_update", k), 128'(pwm_update), 128'(vecs[k].exp_upd));
      check($sformatf("v%0d_crc_error", k), 128'(crc_error), 128'(vecs[k].exp_err));
      check($sformatf("v%0d_crc_cnt", k), 128'(crc_err_cnt), 128'(vecs[k].exp_cnt));
      check($sformatf("v%0d_busy", k), 128'(busy), 128'(1'b0));
      pwm_done = vecs[k].done;
      tick();
      pwm_done = 12'h000;
      check($sformatf("v%0d_update_after_done", k), 128'(pwm_update), 128'(vecs[k].exp_upd_after));
      check($sformatf("v%0d_error_pulse_end", k), 128'(crc_error), 128'(1'b0));
      check($sformatf("v%0d_target_hold", k), 128'(pwm_target), 128'(vecs[k].exp_tgt));
      prev_tgt = vecs[k].exp_tgt;
    end

    // Frame arriving while busy is dropped; in-flight frame completes
    send(mk(4'h5, 8'hA5));
    repeat (GAP - 1) tick();
    send(mk(4'h0, 8'h00));
    check("drop_cnt_one", 128'(drop_cnt), 128'(8'h01));
    repeat (LAT - GAP) tick();
    check("drop_target", 128'(pwm_target), 128'(96'h3C808080_808080A5_80808011));
    check("drop_update", 128'(pwm_update), 128'(12'h010));
    tick();
    check("drop_idle", 128'(busy), 128'(1'b0));
    check("drop_no_late_write", 128'(pwm_target), 128'(96'h3C808080_808080A5_80808011));

    // pwm_done coincident with a write to the same channel
    send(mk(4'h3, 8'h42));
    repeat (LAT - 1) tick();
    pwm_done = 12'h014;
    tick();
    pwm_done = 12'h000;
    check("coinc_target", 128'(pwm_target), 128'(96'h3C808080_808080A5_80428011));
    check("coinc_update", 128'(pwm_update), 128'(12'h004));

    // drop_cnt saturates (accepted frames address nothing)
    frame_data  = mk(4'hE, 8'h00);
    frame_valid = 1'b1;
    repeat (700) tick();
    frame_valid = 1'b0;
    repeat (20) tick();
    check("drop_sat", 128'(drop_cnt), 128'(8'hFF));
    check("drop_sat_target", 128'(pwm_target), 128'(96'h3C808080_808080A5_80428011));
    check("drop_sat_update", 128'(pwm_update), 128'(12'h004));

`ifdef CMD_DEC_CRC_EN
    // crc_err_cnt saturates
    frame_data  = 16'h035A;
    frame_valid = 1'b1;
    repeat (14 * 270) tick();
    frame_valid = 1'b0;
    repeat (20) tick();
    check("crc_sat", 128'(crc_err_cnt), 128'(8'hFF));
    check("crc_sat_target", 128'(pwm_target), 128'(96'h3C808080_808080A5_80428011));
`endif

    // Reset mid-frame discards it
    send(mk(4'h3, 8'h99));
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_target", 128'(pwm_target), 128'(96'h0));
    check("midrst_update", 128'(pwm_update), 128'(12'h000));
    check("midrst_busy", 128'(busy), 128'(1'b0));
    check("midrst_crc_cnt", 128'(crc_err_cnt), 128'(8'h00));
    check("midrst_drop_cnt", 128'(drop_cnt), 128'(8'h00));
    repeat (LAT + 2) tick();
    check("midrst_no_write", 128'(pwm_target), 128'(96'h0));

    // Address above NUM_CH: silently discarded
    send(mk(4'hD, 8'h55));
    repeat (LAT) tick();
    check("addrD_target", 128'(pwm_target), 128'(96'h0));
    check("addrD_update", 128'(pwm_update), 128'(12'h000));
    check("addrD_crc_error", 128'(crc_error), 128'(1'b0));
    tick();
    check("addrD_crc_error_next", 128'(crc_error), 128'(1'b0));
    check("addrD_crc_cnt", 128'(crc_err_cnt), 128'(8'h00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
